// File: rtl/gray_arb_pkg.sv
// Shared types for the gray-image memory arbiter: state encoding, requester id
// and the read-return tag that rides alongside each issued memory read.
package gray_arb_pkg;

  localparam int AW_DEF = 14;
  localparam int DW_DEF = 8;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

  typedef logic req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } rd_tag_t;

endpackage

// File: rtl/gray_rd_tag_pipe.sv
// Delay line for read tags, aligned so the last stage coincides with the cycle
// the memory presents the matching read data.
module gray_rd_tag_pipe
  import gray_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    reset,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out,
  output logic    any_valid
);

  rd_tag_t          stage_reg [DEPTH];
  logic [DEPTH-1:0] valid_vec;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_reg[i] <= '0;
      end
    end else begin
      stage_reg[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) begin
        stage_reg[i] <= stage_reg[i-1];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
      assign valid_vec[gi] = stage_reg[gi].valid;
    end
  endgenerate

  assign tag_out   = stage_reg[DEPTH-1];
  assign any_valid = |valid_vec;

endmodule

// File: rtl/gray_mem_arbiter.sv
// Round-robin arbiter with burst lock sharing one single-port gray-image read
// memory between two pixel-fetch engines; returns tagged read data per engine.
module gray_mem_arbiter
  import gray_arb_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int RD_LAT = 1  // legal range 1..3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic [AW-1:0] m0_addr,
  input  logic          m0_lock,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic [AW-1:0] m1_addr,
  input  logic          m1_lock,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_en,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  arb_state_t state_reg, state_next;
  req_id_t    prio_reg;
  logic       gnt_any;
  req_id_t    gnt_id;
  rd_tag_t    tag_in, tag_out;
  logic       tags_busy;

  always_comb begin
    m0_gnt     = 1'b0;
    m1_gnt     = 1'b0;
    state_next = state_reg;
    case (state_reg)
      ARB: begin
        if (m0_req && (!m1_req || prio_reg == 1'b0)) begin
          m0_gnt = 1'b1;
        end else if (m1_req) begin
          m1_gnt = 1'b1;
        end
        if (m0_gnt && m0_lock) begin
          state_next = LOCK0;
        end else if (m1_gnt && m1_lock) begin
          state_next = LOCK1;
        end
      end
      LOCK0: begin
        m0_gnt = m0_req;
        if (!m0_lock) state_next = ARB;
      end
      LOCK1: begin
        m1_gnt = m1_req;
        if (!m1_lock) state_next = ARB;
      end
      default: state_next = ARB;
    endcase
  end

  assign gnt_any = m0_gnt | m1_gnt;
  assign gnt_id  = m1_gnt;

  // Locked grants also set prio to ~w, which is where it already sits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ARB;
      prio_reg  <= 1'b0;
      mem_en    <= 1'b0;
      mem_addr  <= '0;
    end else begin
      state_reg <= state_next;
      mem_en    <= gnt_any;
      if (gnt_any) begin
        prio_reg <= ~gnt_id;
        mem_addr <= m1_gnt ? m1_addr : m0_addr;
      end
    end
  end

  assign tag_in = '{valid: gnt_any, id: gnt_id};

  gray_rd_tag_pipe #(
    .DEPTH(RD_LAT + 1)
  ) u_tag_pipe (
    .clk      (clk),
    .reset    (reset),
    .tag_in   (tag_in),
    .tag_out  (tag_out),
    .any_valid(tags_busy)
  );

  // Last tag stage lines up with mem_rdata; capture it for the owning engine only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      m0_rvalid <= tag_out.valid && (tag_out.id == 1'b0);
      m1_rvalid <= tag_out.valid && (tag_out.id == 1'b1);
      if (tag_out.valid && tag_out.id == 1'b0) m0_rdata <= mem_rdata;
      if (tag_out.valid && tag_out.id == 1'b1) m1_rdata <= mem_rdata;
    end
  end

  assign busy = (state_reg != ARB) | tags_busy;

endmodule
